// File: rtl/parity_pkg.sv
// Shared definitions for the serial even-parity link (transmitter and checker).
// State encoding and the parity-sense constants live here so both ends agree.
package parity_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_PAR  = 2'b10
  } ptx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_serial_tx.sv
// Serial transmitter: captures a word on a valid/ready handshake, shifts it out one bit
// per clock and appends a parity bit so each frame carries an even (or odd) count of ones.
module parity_serial_tx
  import parity_pkg::*;
#(
  parameter int   DATA_W     = 8,
  parameter bit   MSB_FIRST  = 1'b0,
  parameter logic PARITY_ODD = PAR_EVEN
) (
  input  logic              c,
  input  logic              r_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              so,
  output logic              so_valid,
  output logic              so_last,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  ptx_state_t        state;
  ptx_state_t        state_next;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_adv;
  logic [CNT_W-1:0]  count;
  logic              par;
  logic              accept;
  logic              first_bit;
  logic              next_bit;

  always_comb begin
    din_ready  = (state == ST_IDLE) || (state == ST_PAR);
    accept     = din_valid && din_ready;
    state_next = ST_IDLE;
    case (state)
      ST_IDLE: state_next = accept ? ST_DATA : ST_IDLE;
      ST_DATA: state_next = (count == LAST_CNT) ? ST_PAR : ST_DATA;
      ST_PAR:  state_next = accept ? ST_DATA : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    // so is registered, so the bit shown next cycle is taken from the advanced shift value
    if (MSB_FIRST) begin
      shreg_adv = shreg << 1;
      first_bit = din[DATA_W-1];
      next_bit  = shreg_adv[DATA_W-1];
    end else begin
      shreg_adv = shreg >> 1;
      first_bit = din[0];
      next_bit  = shreg_adv[0];
    end
  end

  always_ff @(posedge c or negedge r_n) begin
    if (!r_n) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      count    <= '0;
      par      <= 1'b0;
      so       <= 1'b0;
      so_valid <= 1'b0;
      so_last  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != ST_IDLE);
      if (accept) begin
        shreg    <= din;
        par      <= (^din) ^ PARITY_ODD;
        count    <= '0;
        so       <= first_bit;
        so_valid <= 1'b1;
        so_last  <= 1'b0;
      end else if (state == ST_DATA) begin
        shreg    <= shreg_adv;
        count    <= count + 1'b1;
        so_valid <= 1'b1;
        if (count == LAST_CNT) begin
          so      <= par;
          so_last <= 1'b1;
        end else begin
          so      <= next_bit;
          so_last <= 1'b0;
        end
      end else begin
        // idle, parity cycle without a new word, or an illegal encoding
        so       <= 1'b0;
        so_valid <= 1'b0;
        so_last  <= 1'b0;
      end
    end
  end

endmodule
